// File: rtl/peripheral_ram_arbiter_tl.sv
// Round-robin arbiter sharing one byte-enabled, 1-cycle-read RAM among NREQ requesters.
// Define PERIPHERAL_RAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module peripheral_ram_arbiter_tl #(
    parameter int NREQ  = 2,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [4*NREQ-1:0]  req_we,
    input  logic [AW*NREQ-1:0] req_addr,
    input  logic [DW*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [NREQ-1:0]    rsp_write,
    output logic [DW*NREQ-1:0] rsp_rdata,
    output logic [3:0]         ram_we,
    output logic [DW-1:0]      ram_din,
    output logic [AW-1:0]      ram_waddr,
    output logic [AW-1:0]      ram_raddr,
    input  logic [DW-1:0]      ram_dout
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || DW != 32 || (1 << AW) < DEPTH) begin : g_bad_cfg
        $error("peripheral_ram_arbiter_tl: unsupported parameter set");
    end

    logic [3:0]    we_a    [NREQ];
    logic [AW-1:0] addr_a  [NREQ];
    logic [DW-1:0] wdata_a [NREQ];
    logic [DW-1:0] rdata_q [NREQ];
    logic [NREQ-1:0] wr_any;

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign we_a[g]    = req_we[4*g +: 4];
        assign addr_a[g]  = req_addr[AW*g +: AW];
        assign wdata_a[g] = req_wdata[DW*g +: DW];
        assign wr_any[g]  = |req_we[4*g +: 4];
        assign rsp_rdata[DW*g +: DW] = rdata_q[g];
    end

    logic [NREQ-1:0] inflight;
    logic [NREQ-1:0] inflight_wr;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;

    // A requester may only issue when its response slot is free or draining.
    always_comb begin
        eligible = req_valid & ~inflight & (~rsp_valid | rsp_ready);
    end

`ifdef PERIPHERAL_RAM_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(i);
            end
        end
        if (rst) gnt_any = 1'b0;
    end
`else
    logic [PW-1:0] rr_ptr;

    // Scan from the far end so the nearest eligible index after rr_ptr sticks.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (eligible[idx[PW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = idx[PW-1:0];
            end
        end
        if (rst) gnt_any = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end
`endif

    always_comb begin
        grant = '0;
        if (gnt_any) grant[gnt_idx] = 1'b1;
    end

    assign req_ready = grant;

    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            din_q  <= '0;
        end else if (gnt_any) begin
            addr_q <= addr_a[gnt_idx];
            din_q  <= wdata_a[gnt_idx];
        end
    end

    // Address/data hold their last value on idle cycles; only we is forced low.
    always_comb begin
        ram_we    = gnt_any ? we_a[gnt_idx] : 4'b0000;
        ram_waddr = gnt_any ? addr_a[gnt_idx] : addr_q;
        ram_raddr = ram_waddr;
        ram_din   = gnt_any ? wdata_a[gnt_idx] : din_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight    <= '0;
            inflight_wr <= '0;
        end else begin
            inflight    <= grant;
            inflight_wr <= grant & wr_any;
        end
    end

    // A landing response cannot collide with an unconsumed one: grant required a free slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_write <= '0;
            for (int i = 0; i < NREQ; i++) rdata_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (inflight[i]) begin
                    rsp_valid[i] <= 1'b1;
                    rsp_write[i] <= inflight_wr[i];
                    rdata_q[i]   <= inflight_wr[i] ? '0 : ram_dout;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_peripheral_ram_arbiter_tl.sv
// Scoreboard bench for peripheral_ram_arbiter_tl with an attached behavioural RAM.
// Honors PERIPHERAL_RAM_ARB_FIXED_PRIO_EN for the expected arbitration order.
module tb_peripheral_ram_arbiter_tl;

    localparam int NREQ  = 2;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [4*NREQ-1:0]  req_we;
    logic [AW*NREQ-1:0] req_addr;
    logic [DW*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [NREQ-1:0]    rsp_write;
    logic [DW*NREQ-1:0] rsp_rdata;
    logic [3:0]         ram_we;
    logic [DW-1:0]      ram_din;
    logic [AW-1:0]      ram_waddr;
    logic [AW-1:0]      ram_raddr;
    logic [DW-1:0]      ram_dout;

    always #5 clk = ~clk;

    peripheral_ram_arbiter_tl #(
        .NREQ(NREQ), .DEPTH(DEPTH), .AW(AW), .DW(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .ram_we(ram_we), .ram_din(ram_din),
        .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
        .ram_dout(ram_dout)
    );

    // Attached RAM: byte-lane writes, registered read.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram[ram_waddr][8*b +: 8] <= ram_din[8*b +: 8];
        ram_dout <= ram[ram_raddr];
    end

    typedef struct packed {
        logic          wr;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0] ref_mem [DEPTH];
    rsp_t exp_q [NREQ][$];
    int   cyc;
    int   gcyc [NREQ];
    bit   mvalid [NREQ];
    int   rr_next;
    int   n_cmp;
    int   n_bad;

    bit            sv   [NREQ];
    logic [3:0]    swe  [NREQ];
    logic [AW-1:0] sa   [NREQ];
    logic [DW-1:0] sd   [NREQ];
    bit            srr  [NREQ];
    bit            srst;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %h required %h", nm, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, advance the model.
    task automatic step();
        int g;
        logic [NREQ-1:0] er;
        logic [NREQ-1:0] mv;
        g = -1;
        rst = srst;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]           = sv[i];
            req_we[4*i +: 4]       = swe[i];
            req_addr[AW*i +: AW]   = sa[i];
            req_wdata[DW*i +: DW]  = sd[i];
            rsp_ready[i]           = srr[i];
        end
        #1;
        if (!srst) begin
            for (int k = 0; k < NREQ; k++) begin
`ifdef PERIPHERAL_RAM_ARB_FIXED_PRIO_EN
                int i = k;
`else
                int i = (rr_next + k) % NREQ;
`endif
                if (g < 0 && sv[i] && gcyc[i] != cyc - 1 && (!mvalid[i] || srr[i]))
                    g = i;
            end
        end
        er = '0;
        mv = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (g == i) er[i] = 1'b1;
            mv[i] = mvalid[i];
        end
        check("req_ready", req_ready, er);
        check("rsp_valid", rsp_valid, mv);
        check("ram_we", ram_we, (g >= 0) ? swe[g] : 4'b0000);
        if (g >= 0) begin
            check("ram_addr", {ram_waddr, ram_raddr}, {sa[g], sa[g]});
            check("ram_din", ram_din, sd[g]);
        end
        @(negedge clk);
        #1;
        if (srst) begin
            for (int i = 0; i < NREQ; i++) begin
                exp_q[i].delete();
                mvalid[i] = 1'b0;
                gcyc[i] = -10;
            end
            rr_next = 0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gcyc[i] == cyc - 1) mvalid[i] = 1'b1;
                else if (mvalid[i] && srr[i]) mvalid[i] = 1'b0;
            end
            if (g >= 0) begin
                rsp_t e;
                e.wr   = (swe[g] != 4'b0000);
                e.data = e.wr ? '0 : ref_mem[sa[g]];
                exp_q[g].push_back(e);
                for (int b = 0; b < 4; b++)
                    if (swe[g][b]) ref_mem[sa[g]][8*b +: 8] = sd[g][8*b +: 8];
                gcyc[g] = cyc;
                rr_next = (g + 1) % NREQ;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        for (int i = 0; i < NREQ; i++) begin
            sv[i] = 1'b0;
            swe[i] = 4'b0000;
            sa[i] = '0;
            sd[i] = '0;
            srr[i] = 1'b1;
        end
        srst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [3:0] we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        sv[i] = 1'b1;
        swe[i] = we;
        sa[i] = a;
        sd[i] = d;
    endtask

    // Monitor: pops the scoreboard on each response handshake, checks hold under backpressure.
    rsp_t mon_e;
    bit   held_v [NREQ];
    rsp_t held   [NREQ];
    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (held_v[i] && rsp_valid[i] === 1'b1)
                check("rsp_hold", {rsp_write[i], rsp_rdata[DW*i +: DW]}, held[i]);
            if (rsp_valid[i] === 1'b1 && rsp_ready[i] === 1'b1) begin
                if (exp_q[i].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_unexpected req%0d cyc=%0d: got a response, required none",
                             i, cyc);
                end else begin
                    mon_e = exp_q[i].pop_front();
                    check("rsp_data", {rsp_write[i], rsp_rdata[DW*i +: DW]}, mon_e);
                end
            end
            held_v[i] = (rsp_valid[i] === 1'b1 && rsp_ready[i] === 1'b0);
            held[i]   = {rsp_write[i], rsp_rdata[DW*i +: DW]};
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        rr_next = 0;
        for (int i = 0; i < NREQ; i++) begin
            gcyc[i] = -10;
            mvalid[i] = 1'b0;
            held_v[i] = 1'b0;
        end
        for (int a = 0; a < DEPTH; a++) begin
            ram[a] = '0;
            ref_mem[a] = '0;
        end
        ram[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        ram[7] = 32'hAABBCCDD;
        ref_mem[7] = 32'hAABBCCDD;

        idle();
        srst = 1'b1;
        rst = 1'b1;
        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        rsp_ready = '1;
        @(posedge clk);
        #1;

        // Reset with a pending write request: it must not reach the RAM.
        set_req(0, 4'hF, 8'd9, 32'h12345678);
        step();
        step();
        check("rst_rdata", rsp_rdata, '0);
        check("rst_write", rsp_write, '0);

        // Single read.
        idle();
        set_req(0, 4'h0, 8'd5, '0);
        step();
        idle();
        repeat (3) step();

        // Partial write then read back; reset-cycle write must be absent at addr 9.
        set_req(1, 4'b0011, 8'd7, 32'h11223344);
        step();
        idle();
        step();
        set_req(1, 4'h0, 8'd7, '0);
        step();
        idle();
        set_req(0, 4'h0, 8'd9, '0);
        step();
        idle();
        repeat (2) step();

        // Write by one requester, read same address by the other next cycle.
        set_req(0, 4'hF, 8'd20, 32'hCAFEF00D);
        step();
        idle();
        set_req(1, 4'h0, 8'd20, '0);
        step();
        idle();
        repeat (3) step();

        // Contention: both hold reads every cycle.
        set_req(0, 4'h0, 8'd5, '0);
        set_req(1, 4'h0, 8'd7, '0);
        repeat (9) step();
        idle();
        repeat (3) step();

        // Backpressure on requester 0 while requester 1 keeps issuing.
        set_req(0, 4'h0, 8'd5, '0);
        step();
        idle();
        step();
        set_req(0, 4'h0, 8'd7, '0);
        set_req(1, 4'h0, 8'd20, '0);
        srr[0] = 1'b0;
        repeat (5) step();
        srr[0] = 1'b1;
        repeat (3) step();
        idle();
        repeat (3) step();

        // Reset the cycle after a grant to requester 0.
        set_req(1, 4'h0, 8'd5, '0);
        step();
        idle();
        set_req(0, 4'hF, 8'd30, 32'h0BADF00D);
        step();
        idle();
        srst = 1'b1;
        step();
        step();
        idle();
        set_req(0, 4'h0, 8'd30, '0);
        set_req(1, 4'h0, 8'd5, '0);
        step();
        idle();
        repeat (4) step();

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                sv[i]  = ($urandom_range(0, 3) != 0);
                swe[i] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                sa[i]  = AW'($urandom_range(0, 15));
                sd[i]  = $urandom;
                srr[i] = ($urandom_range(0, 3) != 0);
            end
            srst = ($urandom_range(0, 99) == 0);
            step();
        end

        idle();
        repeat (6) step();
        for (int i = 0; i < NREQ; i++)
            check("drain", 64'(exp_q[i].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
